// File: rtl/spike_rate_decoder_pkg.sv
// Shared state encoding, default sizing and helpers for the spike rate decoder.
package spike_rate_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_NUM_NEURONS   = 8;
    localparam int DEF_WINDOW_CYCLES = 64;
    localparam int DEF_COUNT_WIDTH   = 8;

    // Ceiling log2 with a floor of one bit so single-entry ranges still get a port.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/spike_lane_counter.sv
// One spike lane: saturating counter, saturation flag and, when
// SPIKE_RATE_DECODER_FIRST_SPIKE_EN is defined, the first-spike timestamp.
module spike_lane_counter #(
    parameter int COUNT_WIDTH = 8,
    parameter int TIME_WIDTH  = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   inc,
    input  logic [TIME_WIDTH-1:0]  win_cnt,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   sat,
    output logic [TIME_WIDTH-1:0]  first_time
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    // The flag marks the window in which the counter reached its ceiling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
            if (count == (CNT_MAX - CNT_ONE)) begin
                sat <= 1'b1;
            end
        end
    end

`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
    logic fired;

    // A separate fired bit keeps a spike on the final window cycle distinct from "never fired".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fired      <= 1'b0;
            first_time <= '1;
        end else if (clear) begin
            fired      <= 1'b0;
            first_time <= '1;
        end else if (inc && !fired) begin
            fired      <= 1'b1;
            first_time <= win_cnt;
        end
    end
`else
    logic unused_win_cnt;

    assign unused_win_cnt = ^win_cnt;
    assign first_time     = '1;
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed per-lane spike counting followed by a sequential argmax scan, with a valid/ready result.
// Optional first-spike tie-breaking is enabled by defining SPIKE_RATE_DECODER_FIRST_SPIKE_EN.
module spike_rate_decoder
    import spike_rate_decoder_pkg::*;
#(
    parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH,
    parameter int IDX_WIDTH     = clog2(NUM_NEURONS),
    parameter int TIME_WIDTH    = clog2(WINDOW_CYCLES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [NUM_NEURONS-1:0]            spikes_in,
    input  logic                              spikes_valid,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*COUNT_WIDTH-1:0] counts_out,
    output logic [IDX_WIDTH-1:0]              winner_idx,
    output logic [COUNT_WIDTH-1:0]            winner_count,
    output logic                              tie,
    output logic                              no_spike,
    output logic                              saturated,
    output logic [NUM_NEURONS*TIME_WIDTH-1:0] first_spike_out
);

    localparam logic [TIME_WIDTH-1:0] WIN_LAST  = TIME_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [TIME_WIDTH-1:0] TIME_ONE  = TIME_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0]  SCAN_LAST = IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE   = IDX_WIDTH'(1);

    state_t                  state;
    logic [TIME_WIDTH-1:0]   win_cnt;
    logic [IDX_WIDTH-1:0]    scan_idx;
    logic [COUNT_WIDTH-1:0]  lane_count [NUM_NEURONS];
    logic [TIME_WIDTH-1:0]   lane_time  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]  lane_sat;
    logic [NUM_NEURONS-1:0]  lane_inc;
    logic                    abort_hit;
    logic                    accept;
    logic                    restart;
    logic                    clear_lanes;
    logic                    scan_done;

    logic [COUNT_WIDTH-1:0]  best_cnt, cur_cnt, nxt_cnt;
    logic [IDX_WIDTH-1:0]    best_idx, nxt_idx;
    logic                    best_tie, nxt_tie;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
    logic [TIME_WIDTH-1:0]   best_time, cur_time, nxt_time;
`endif

    assign abort_hit   = abort && (state != IDLE);
    assign accept      = (state == HOLD) && out_valid && out_ready;
    assign restart     = ((state == IDLE) && start) || (accept && start);
    assign clear_lanes = restart || abort_hit;
    assign scan_done   = (state == SCAN) && (scan_idx == SCAN_LAST);
    assign lane_inc    = ((state == ACCUM) && spikes_valid && !abort) ? spikes_in : '0;

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
        spike_lane_counter #(
            .COUNT_WIDTH (COUNT_WIDTH),
            .TIME_WIDTH  (TIME_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clear      (clear_lanes),
            .inc        (lane_inc[i]),
            .win_cnt    (win_cnt),
            .count      (lane_count[i]),
            .sat        (lane_sat[i]),
            .first_time (lane_time[i])
        );

        assign counts_out[i*COUNT_WIDTH +: COUNT_WIDTH]    = lane_count[i];
        assign first_spike_out[i*TIME_WIDTH +: TIME_WIDTH] = lane_time[i];
    end

    // Abort outranks every other transition once a window is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            win_cnt   <= '0;
            scan_idx  <= '0;
        end else if (abort_hit) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            win_cnt   <= '0;
            scan_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACCUM;
                        busy    <= 1'b1;
                        win_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (win_cnt == WIN_LAST) begin
                        state    <= SCAN;
                        win_cnt  <= '0;
                        scan_idx <= '0;
                    end else begin
                        win_cnt <= win_cnt + TIME_ONE;
                    end
                end
                SCAN: begin
                    scan_idx <= scan_idx + IDX_ONE;
                    if (scan_idx == SCAN_LAST) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        scan_idx  <= '0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        win_cnt   <= '0;
                        if (start) begin
                            state <= ACCUM;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Compare the lane under the scan pointer against the running best.
    always_comb begin
        cur_cnt = lane_count[scan_idx];
        nxt_cnt = best_cnt;
        nxt_idx = best_idx;
        nxt_tie = best_tie;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
        cur_time = lane_time[scan_idx];
        nxt_time = best_time;
        if ((cur_cnt > best_cnt) ||
            ((cur_cnt == best_cnt) && (cur_cnt != '0) && (cur_time < best_time))) begin
            nxt_cnt  = cur_cnt;
            nxt_idx  = scan_idx;
            nxt_time = cur_time;
            nxt_tie  = 1'b0;
        end else if ((cur_cnt == best_cnt) && (cur_cnt != '0) && (cur_time == best_time)) begin
            nxt_tie = 1'b1;
        end
`else
        if (cur_cnt > best_cnt) begin
            nxt_cnt = cur_cnt;
            nxt_idx = scan_idx;
            nxt_tie = 1'b0;
        end else if ((cur_cnt == best_cnt) && (cur_cnt != '0)) begin
            nxt_tie = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_cnt  <= '0;
            best_idx  <= '0;
            best_tie  <= 1'b0;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
            best_time <= '1;
`endif
        end else if (state != SCAN) begin
            best_cnt  <= '0;
            best_idx  <= '0;
            best_tie  <= 1'b0;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
            best_time <= '1;
`endif
        end else begin
            best_cnt  <= nxt_cnt;
            best_idx  <= nxt_idx;
            best_tie  <= nxt_tie;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
            best_time <= nxt_time;
`endif
        end
    end

    // Result registers only move at window start, abort, or the final scan step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            winner_idx   <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            no_spike     <= 1'b0;
            saturated    <= 1'b0;
        end else if (clear_lanes) begin
            winner_idx   <= '0;
            winner_count <= '0;
            tie          <= 1'b0;
            no_spike     <= 1'b0;
            saturated    <= 1'b0;
        end else if (scan_done) begin
            winner_idx   <= nxt_idx;
            winner_count <= nxt_cnt;
            tie          <= nxt_tie;
            no_spike     <= (nxt_cnt == '0);
            saturated    <= |lane_sat;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: vector table plus hand-built abort/reset/hold sequences.
module tb_spike_rate_decoder;

    localparam int NV = 7;

    typedef struct {
        logic [7:0][7:0] first;
        logic [7:0][7:0] period;
        logic [7:0][7:0] num;
        logic [7:0][7:0] exp_counts;
        int              valid_mod;
        int              exp_idx;
        int              exp_wcount;
        bit              exp_tie;
        bit              exp_no_spike;
        bit              exp_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  spikes_in;
    logic        spikes_valid;
    logic        out_ready;

    logic        busy, out_valid, tie, no_spike, saturated;
    logic [63:0] counts_out;
    logic [2:0]  winner_idx;
    logic [7:0]  winner_count;
    logic [47:0] first_spike_out;

    logic        busy4, out_valid4, tie4, no_spike4, saturated4;
    logic [31:0] counts4;
    logic [2:0]  winner_idx4;
    logic [3:0]  winner_count4;
    logic [47:0] first_spike4;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    spike_rate_decoder #(.NUM_NEURONS(8), .WINDOW_CYCLES(64), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .spikes_in(spikes_in), .spikes_valid(spikes_valid),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .counts_out(counts_out), .winner_idx(winner_idx), .winner_count(winner_count),
        .tie(tie), .no_spike(no_spike), .saturated(saturated),
        .first_spike_out(first_spike_out)
    );

    spike_rate_decoder #(.NUM_NEURONS(8), .WINDOW_CYCLES(64), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .spikes_in(spikes_in), .spikes_valid(spikes_valid),
        .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready),
        .counts_out(counts4), .winner_idx(winner_idx4), .winner_count(winner_count4),
        .tie(tie4), .no_spike(no_spike4), .saturated(saturated4),
        .first_spike_out(first_spike4)
    );

    function automatic vec_t blank();
        vec_t v;
        v.first = '0; v.period = '0; v.num = '0; v.exp_counts = '0;
        v.valid_mod = 0; v.exp_idx = 0; v.exp_wcount = 0;
        v.exp_tie = 1'b0; v.exp_no_spike = 1'b0; v.exp_sat = 1'b0;
        return v;
    endfunction

    function automatic vec_t with_lane(vec_t v, int lane, int f, int p, int n, int cnt);
        v.first[lane]      = 8'(f);
        v.period[lane]     = 8'(p);
        v.num[lane]        = 8'(n);
        v.exp_counts[lane] = 8'(cnt);
        return v;
    endfunction

    function automatic bit lane_fires(vec_t v, int lane, int k);
        int f, p, n;
        f = int'(v.first[lane]);
        p = int'(v.period[lane]);
        n = int'(v.num[lane]);
        if (n == 0 || p == 0 || k < f) return 1'b0;
        if (((k - f) % p) != 0) return 1'b0;
        return ((k - f) / p) < n;
    endfunction

    function automatic bit valid_at(vec_t v, int k);
        if (v.valid_mod == 0) return 1'b1;
        return (k % v.valid_mod) != (v.valid_mod - 1);
    endfunction

    function automatic logic [47:0] exp_first(vec_t v);
        logic [47:0] r;
        bit hit;
        r = '1;
        for (int lane = 0; lane < 8; lane++) begin
            for (int k = 63; k >= 0; k--) begin
                hit = lane_fires(v, lane, k) && valid_at(v, k);
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
                if (hit) r[lane*6 +: 6] = 6'(k);
`else
                if (hit) r[lane*6 +: 6] = 6'h3f;
`endif
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string what, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    // Runs one full window; leaves the DUT in HOLD with spikes driven high to prove they are dropped.
    task automatic applyStimulus(input vec_t v, input bit issue_start, output int latency);
        int cycles;
        if (issue_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        cycles = 1;
        for (int k = 0; k < 64; k++) begin
            spikes_valid = valid_at(v, k);
            for (int i = 0; i < 8; i++) spikes_in[i] = lane_fires(v, i, k);
            @(posedge clk); #1;
            cycles++;
        end
        spikes_in    = 8'hff;
        spikes_valid = 1'b1;
        for (int w = 0; w < 40; w++) begin
            if (out_valid) break;
            @(posedge clk); #1;
            cycles++;
        end
        latency = cycles;
    endtask

    task automatic acceptResult(input bit restart, input string tag);
        spikes_in    = '0;
        spikes_valid = 1'b0;
        out_ready    = 1'b1;
        start        = restart;
        @(posedge clk); #1;
        out_ready    = 1'b0;
        start        = 1'b0;
        checkOutput({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " busy after accept"}, 64'(busy), 64'(restart));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, " counts"}, counts_out, 64'd0);
        checkOutput({tag, " winner"}, {52'd0, tie, no_spike, saturated, winner_idx, winner_count}, 64'd0);
        checkOutput({tag, " first_spike"}, 64'(first_spike_out), 64'hffff_ffff_ffff);
        checkOutput({tag, " dut4 state"}, {counts4, 7'd0, busy4, out_valid4, tie4, no_spike4, saturated4,
                                           winner_idx4, winner_count4, 1'b0}, 64'd0);
        checkOutput({tag, " dut4 first_spike"}, 64'(first_spike4), 64'hffff_ffff_ffff);
    endtask

    task automatic watchNoResult(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (out_valid || out_valid4) seen = 1'b1;
        end
        checkOutput({tag, " no out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t v;
        int   lat;
        logic [63:0] exp_counts_v0;

        vecs[0] = with_lane(with_lane(blank(), 3, 0, 1, 64, 64), 5, 0, 2, 32, 32);
        vecs[0].exp_idx = 3; vecs[0].exp_wcount = 64;

        vecs[1] = blank();
        vecs[1].exp_no_spike = 1'b1;

        vecs[2] = with_lane(with_lane(blank(), 2, 20, 2, 10, 10), 6, 5, 3, 10, 10);
        vecs[2].exp_wcount = 10;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
        vecs[2].exp_idx = 6; vecs[2].exp_tie = 1'b0;
`else
        vecs[2].exp_idx = 2; vecs[2].exp_tie = 1'b1;
`endif

        vecs[3] = with_lane(with_lane(blank(), 1, 0, 1, 64, 48), 0, 1, 1, 5, 4);
        vecs[3].valid_mod = 4; vecs[3].exp_idx = 1; vecs[3].exp_wcount = 48;

        vecs[4] = with_lane(with_lane(with_lane(blank(), 0, 10, 1, 7, 7), 4, 0, 1, 7, 7), 7, 30, 1, 7, 7);
        vecs[4].exp_wcount = 7;
`ifdef SPIKE_RATE_DECODER_FIRST_SPIKE_EN
        vecs[4].exp_idx = 4; vecs[4].exp_tie = 1'b0;
`else
        vecs[4].exp_idx = 0; vecs[4].exp_tie = 1'b1;
`endif

        vecs[5] = with_lane(with_lane(with_lane(blank(), 1, 2, 4, 5, 5), 3, 2, 4, 5, 5), 7, 40, 1, 3, 3);
        vecs[5].exp_idx = 1; vecs[5].exp_wcount = 5; vecs[5].exp_tie = 1'b1;

        vecs[6] = with_lane(with_lane(blank(), 0, 1, 1, 63, 63), 7, 0, 1, 64, 64);
        vecs[6].exp_idx = 7; vecs[6].exp_wcount = 64;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        spikes_in = '0; spikes_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < NV; n++) begin
            string tag;
            tag = $sformatf("v%0d", n);
            applyStimulus(vecs[n], 1'b1, lat);
            checkOutput({tag, " latency"}, 64'(lat), 64'd73);
            checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, " busy"}, 64'(busy), 64'd1);
            checkOutput({tag, " counts"}, counts_out, vecs[n].exp_counts);
            checkOutput({tag, " winner_idx"}, 64'(winner_idx), 64'(vecs[n].exp_idx));
            checkOutput({tag, " winner_count"}, 64'(winner_count), 64'(vecs[n].exp_wcount));
            checkOutput({tag, " tie"}, 64'(tie), 64'(vecs[n].exp_tie));
            checkOutput({tag, " no_spike"}, 64'(no_spike), 64'(vecs[n].exp_no_spike));
            checkOutput({tag, " saturated"}, 64'(saturated), 64'(vecs[n].exp_sat));
            checkOutput({tag, " first_spike"}, 64'(first_spike_out), 64'(exp_first(vecs[n])));
            acceptResult(1'b0, tag);
        end

        // Saturation on the 4-bit instance, then a clean window clears the flag.
        v = with_lane(blank(), 0, 0, 1, 20, 20);
        applyStimulus(v, 1'b1, lat);
        checkOutput("sat4 counts", 64'(counts4), 64'h0000_000f);
        checkOutput("sat4 saturated", 64'(saturated4), 64'd1);
        checkOutput("sat4 winner_count", 64'(winner_count4), 64'd15);
        checkOutput("sat4 winner_idx", 64'(winner_idx4), 64'd0);
        checkOutput("sat8 counts", counts_out, 64'd20);
        checkOutput("sat8 saturated", 64'(saturated), 64'd0);
        acceptResult(1'b0, "sat4");
        v = with_lane(blank(), 0, 0, 1, 3, 3);
        applyStimulus(v, 1'b1, lat);
        checkOutput("sat4 next counts", 64'(counts4), 64'd3);
        checkOutput("sat4 next saturated", 64'(saturated4), 64'd0);
        checkOutput("sat4 next winner_count", 64'(winner_count4), 64'd3);
        acceptResult(1'b0, "sat4 next");

        // Backpressure in HOLD, then accept with start chains straight into a new window.
        exp_counts_v0 = vecs[0].exp_counts;
        applyStimulus(vecs[0], 1'b1, lat);
        for (int c = 0; c < 10; c++) begin
            bit ok;
            ok = out_valid && busy && (winner_idx == 3'd3) && (winner_count == 8'd64) &&
                 (counts_out == exp_counts_v0) && !tie && !no_spike;
            checkOutput($sformatf("hold stable c%0d", c), 64'(ok), 64'd1);
            @(posedge clk); #1;
        end
        acceptResult(1'b1, "hold restart");
        applyStimulus(vecs[1], 1'b0, lat);
        checkOutput("restart latency", 64'(lat), 64'd73);
        checkOutput("restart no_spike", 64'(no_spike), 64'd1);
        checkOutput("restart counts", counts_out, 64'd0);
        checkOutput("restart winner", {61'd0, winner_idx}, 64'd0);
        acceptResult(1'b0, "restart");

        // Abort when win_cnt is 30.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            spikes_valid = 1'b1;
            spikes_in    = 8'h02;
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        spikes_in = '0; spikes_valid = 1'b0;
        checkReset("abort");
        watchNoResult("abort");

        // Asynchronous reset while scanning.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            spikes_valid = 1'b1;
            spikes_in    = 8'h04;
            @(posedge clk); #1;
        end
        spikes_in = '0; spikes_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkReset("rst in scan");
        @(posedge clk); #1;
        rst = 1'b0;
        watchNoResult("rst in scan");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
